mdu_hilo: RTL
=============

Name: mdu_hilo

Overview:
- Multiply/divide unit with architectural HI/LO registers.
- Sits beside the EXE stage and consumes its one-hot mult/div op, operands and move-to data.
- Runs multi-cycle signed/unsigned division and returns completion to EXE via div_tready_out.
- Commits MULT/DIV/MTHI/MTLO results only when the instruction leaves EXE. Serves MFHI/MFLO reads.

Parameters:
- DATA_W, 32, operand width (only 32 supported).
- DIV_STEPS, 32, restoring-division iterations (must equal DATA_W).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- exe_valid_in  in  1  EXE holds a valid instruction (pre-ready).
- exe_fire_in  in  1  EXE instruction transfers to MEM this cycle (valid && ready && mem_allowin).
- exe_mult_div_op_in  in  8  one-hot {0:MULT,1:MULTU,2:DIV,3:DIVU,4:MFHI,5:MFLO,6:MTHI,7:MTLO}.
- exe_in0_in  in  32  dividend / multiplicand (rs).
- exe_in1_in  in  32  divisor / multiplier (rt).
- exe_mthiol_data_in  in  32  MTHI/MTLO source data.
- wb_ClrStpJmp_in  in  1  pipeline flush from WB.
- div_tready_out  out  1  1 = no division result pending; 0 = division result ready in DONE.
- hi_out  out  32  HI register.
- lo_out  out  32  LO register.
- mfhiol_data_out  out  32  op[4] ? HI : LO, combinational from the registers.

Behaviour:
- Reset: HI=LO=0, state IDLE, counter=0, div_tready_out=1, internal quotient/remainder = 0.
- States: IDLE, BUSY, FIX, DONE. div_tready_out=0 only in DONE.
- IDLE -> BUSY: exe_valid_in && (op[2]|op[3]) && !wb_ClrStpJmp_in.
  - Latch |dividend|, |divisor|, signedness, sign(a), sign(b); counter=0.
  - For DIVU or operands with op[3], the magnitude is the raw value.
- BUSY:
  - One restoring step per cycle: shift the remainder:dividend pair left 1, trial-subtract the divisor, set the quotient bit on non-negative result.
  - counter++. After step DIV_STEPS-1 -> FIX.
- FIX, one cycle:
  - Signed: quotient negated if sign(a)^sign(b); remainder negated if sign(a).
  - Divisor==0: quotient=0xFFFFFFFF, remainder=dividend (original value), regardless of sign.
  - -> DONE.
- DONE:
  - Hold the result and div_tready_out=0 until exe_fire_in.
  - On exe_fire_in: LO<=quotient, HI<=remainder; -> IDLE.
- Latency: op first seen valid in IDLE = cycle 0; BUSY cycles 1–32; FIX cycle 33; div_tready_out low from cycle 34.
- MULT/MULTU:
  - Combinational 64-bit product; signed for op[0], unsigned for op[1].
  - On exe_fire_in: {HI,LO}<=product.
- MTHI/MTLO: on exe_fire_in, HI (op[6]) or LO (op[7]) <= exe_mthiol_data_in.
- MFHI/MFLO: no state change. A value written by a fire in cycle N is visible on mfhiol_data_out from cycle N+1.
- Flush (wb_ClrStpJmp_in=1):
  - Any state -> IDLE and div_tready_out=1 next cycle.
  - No HI/LO write that cycle, even if exe_fire_in=1. Flush has priority over fire.
- rst mid-division: same as flush, plus HI/LO cleared.
- exe_fire_in with a div op outside DONE cannot occur (EXE not ready). It must not write HI/LO.
- exe_fire_in with op=0: no effect.
- Ops are one-hot. Behaviour with multiple bits set is unspecified. Assert in simulation.

Test Plan:
- MULT 0xFFFFFFFD × 0x00000005, fire in cycle 0 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1 in cycle 1. Then MULTU 0xFFFFFFFF × 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
- DIV 0xFFFFFFF9 / 0x00000002, fire held low 3 extra cycles after DONE:
  - div_tready_out=1 in cycles 0–33, 0 from cycle 34 until fire.
  - On fire: LO=0xFFFFFFFD, HI=0xFFFFFFFF; div_tready_out=1 the next cycle.
- DIVU 0x80000000 / 0x00000003 -> LO=0x2AAAAAAA, HI=0x00000002.
- DIVU 0x12345678 / 0 -> LO=0xFFFFFFFF, HI=0x12345678.
- DIV started, wb_ClrStpJmp_in=1 in cycle 10:
  - IDLE and div_tready_out=1 in cycle 11; HI/LO unchanged.
  - A new DIVU 9/4 then completes normally: LO=2, HI=1.
- MTHI 0xDEADBEEF fire, next cycle MFHI -> mfhiol_data_out=0xDEADBEEF.
  - MTLO fire coincident with flush -> LO unchanged.
  - rst -> HI=LO=0.

Source files
------------

// File: rtl/mdu_hilo.sv
// Multiply/divide unit owning the architectural HI/LO registers.
// Writes to HI/LO commit only when the owning instruction leaves EXE.
module mdu_hilo #(
  parameter int DATA_W    = 32,
  parameter int DIV_STEPS = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              exe_valid_in,
  input  logic              exe_fire_in,
  input  logic [7:0]        exe_mult_div_op_in,
  input  logic [DATA_W-1:0] exe_in0_in,
  input  logic [DATA_W-1:0] exe_in1_in,
  input  logic [DATA_W-1:0] exe_mthiol_data_in,
  input  logic              wb_ClrStpJmp_in,
  output logic              div_tready_out,
  output logic [DATA_W-1:0] hi_out,
  output logic [DATA_W-1:0] lo_out,
  output logic [DATA_W-1:0] mfhiol_data_out
);

  localparam int CW = $clog2(DIV_STEPS + 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_FIX, S_DONE} state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [DATA_W-1:0] hi, lo;
  logic [DATA_W-1:0] quo, rem, dvs, a_raw;
  logic              sgn, a_neg_r, b_neg_r;

  logic [7:0]        op;
  logic              is_div, is_mul, wr_ok;
  logic              a_neg, b_neg;
  logic [DATA_W-1:0] a_mag, b_mag;
  logic [DATA_W:0]   rem_sh, diff;
  logic signed [2*DATA_W-1:0] prod_s;
  logic [2*DATA_W-1:0]        prod_u, prod;

  assign op     = exe_mult_div_op_in;
  assign is_div = op[2] | op[3];
  assign is_mul = op[0] | op[1];
  // A flush cancels the leaving instruction, so it never commits.
  assign wr_ok  = exe_fire_in & ~wb_ClrStpJmp_in;

  assign a_neg = op[2] & exe_in0_in[DATA_W-1];
  assign b_neg = op[2] & exe_in1_in[DATA_W-1];
  assign a_mag = a_neg ? -exe_in0_in : exe_in0_in;
  assign b_mag = b_neg ? -exe_in1_in : exe_in1_in;

  // Quotient bits accumulate in quo as the dividend shifts out of it.
  assign rem_sh = {rem, quo[DATA_W-1]};
  assign diff   = rem_sh - {1'b0, dvs};

  assign prod_s = $signed(exe_in0_in) * $signed(exe_in1_in);
  assign prod_u = {{DATA_W{1'b0}}, exe_in0_in} * {{DATA_W{1'b0}}, exe_in1_in};
  assign prod   = op[0] ? prod_s : prod_u;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      cnt            <= '0;
      hi             <= '0;
      lo             <= '0;
      quo            <= '0;
      rem            <= '0;
      dvs            <= '0;
      a_raw          <= '0;
      sgn            <= 1'b0;
      a_neg_r        <= 1'b0;
      b_neg_r        <= 1'b0;
      div_tready_out <= 1'b1;
    end else begin
      if (wb_ClrStpJmp_in) begin
        state          <= S_IDLE;
        div_tready_out <= 1'b1;
      end else begin
        case (state)
          S_IDLE: if (exe_valid_in && is_div) begin
            quo     <= a_mag;
            rem     <= '0;
            dvs     <= b_mag;
            a_raw   <= exe_in0_in;
            sgn     <= op[2];
            a_neg_r <= a_neg;
            b_neg_r <= b_neg;
            cnt     <= '0;
            state   <= S_BUSY;
          end
          S_BUSY: begin
            rem <= diff[DATA_W] ? rem_sh[DATA_W-1:0] : diff[DATA_W-1:0];
            quo <= {quo[DATA_W-2:0], ~diff[DATA_W]};
            cnt <= cnt + 1'b1;
            if (cnt == CW'(DIV_STEPS - 1)) state <= S_FIX;
          end
          S_FIX: begin
            if (dvs == '0) begin
              quo <= '1;
              rem <= a_raw;
            end else begin
              if (sgn && (a_neg_r ^ b_neg_r)) quo <= -quo;
              if (sgn && a_neg_r)             rem <= -rem;
            end
            state          <= S_DONE;
            div_tready_out <= 1'b0;
          end
          S_DONE: if (exe_fire_in && is_div) begin
            lo             <= quo;
            hi             <= rem;
            state          <= S_IDLE;
            div_tready_out <= 1'b1;
          end
          default: state <= S_IDLE;
        endcase
      end
      if (wr_ok) begin
        if (is_mul) begin
          hi <= prod[2*DATA_W-1:DATA_W];
          lo <= prod[DATA_W-1:0];
        end
        if (op[6]) hi <= exe_mthiol_data_in;
        if (op[7]) lo <= exe_mthiol_data_in;
      end
    end
  end

  assign hi_out          = hi;
  assign lo_out          = lo;
  assign mfhiol_data_out = op[4] ? hi : lo;

`ifndef SYNTHESIS
  always @(posedge clk)
    if (!rst && exe_valid_in) assert ($onehot0(exe_mult_div_op_in));
`endif

endmodule
